// File: rtl/ex_stage_if.sv
// ID/EX-to-EX/MEM bundle for the execute stage: ID/EX register outputs in,
// EX/MEM register outputs and the upstream stall out.
interface ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              i_flush;
    logic [DATA_W-1:0] i_next_pc;
    logic [DATA_W-1:0] i_read_data1;
    logic [DATA_W-1:0] i_read_data2;
    logic [DATA_W-1:0] i_imm;
    logic [REG_AW-1:0] i_tar_reg;
    logic [REG_AW-1:0] i_des_reg;
    logic [1:0]        i_WB_control;
    logic [2:0]        i_MEM_control;
    logic [3:0]        i_EX_control;
    logic              o_stall;
    logic [DATA_W-1:0] o_branch_target;
    logic              o_zero;
    logic [DATA_W-1:0] o_alu_result;
    logic [DATA_W-1:0] o_write_data;
    logic [REG_AW-1:0] o_write_reg;
    logic [1:0]        o_WB_control;
    logic [2:0]        o_MEM_control;

    modport master (
        output i_flush, i_next_pc, i_read_data1, i_read_data2, i_imm,
               i_tar_reg, i_des_reg, i_WB_control, i_MEM_control, i_EX_control,
        input  o_stall, o_branch_target, o_zero, o_alu_result, o_write_data,
               o_write_reg, o_WB_control, o_MEM_control
    );

    modport slave (
        input  i_flush, i_next_pc, i_read_data1, i_read_data2, i_imm,
               i_tar_reg, i_des_reg, i_WB_control, i_MEM_control, i_EX_control,
        output o_stall, o_branch_target, o_zero, o_alu_result, o_write_data,
               o_write_reg, o_WB_control, o_MEM_control
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch target and EX/MEM register. Define EX_MULT_EN to
// include the 32-cycle shift-add multiplier that stalls the upstream stages.
module ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic     i_clk,
    input  logic     i_rst,
    ex_stage_if.slave bus
);
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_MULT = 6'b011000;

    function automatic logic signed [DATA_W-1:0] alu_f(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b,
        input logic [1:0]               op,
        input logic [5:0]               funct
    );
        alu_f = '0;
        case (op)
            2'b00: alu_f = a + b;
            2'b01: alu_f = a - b;
            2'b11: alu_f = a | b;
            default: begin
                case (funct)
                    F_ADD:   alu_f = a + b;
                    F_SUB:   alu_f = a - b;
                    F_AND:   alu_f = a & b;
                    F_OR:    alu_f = a | b;
                    F_SLT:   alu_f = (a < b) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
                    default: alu_f = '0;
                endcase
            end
        endcase
    endfunction

    // Stage p0: combinational execute on the ID/EX contents
    logic signed [DATA_W-1:0] op_a_p0, op_b_p0, alu_p0;
    logic [DATA_W-1:0]        br_tgt_p0;
    logic [REG_AW-1:0]        wr_p0;
    logic [1:0]               aluop_p0;
    logic [5:0]               funct_p0;

    assign aluop_p0  = bus.i_EX_control[2:1];
    assign funct_p0  = bus.i_imm[5:0];
    assign op_a_p0   = $signed(bus.i_read_data1);
    assign op_b_p0   = bus.i_EX_control[3] ? $signed(bus.i_imm) : $signed(bus.i_read_data2);
    assign alu_p0    = alu_f(op_a_p0, op_b_p0, aluop_p0, funct_p0);
    assign br_tgt_p0 = bus.i_next_pc + {bus.i_imm[DATA_W-3:0], 2'b00};
    assign wr_p0     = bus.i_EX_control[0] ? bus.i_des_reg : bus.i_tar_reg;

    logic              bubble_p0, done_p0;
    logic [DATA_W-1:0] prod_p0;
    logic [REG_AW-1:0] cap_wr_p0;
    logic [1:0]        cap_wb_p0;
    logic [2:0]        cap_mem_p0;

`ifdef EX_MULT_EN
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [4:0]        count;
    logic [DATA_W-1:0] acc, mcand, mplier;
    logic              mult_p0;

    assign mult_p0   = (aluop_p0 == 2'b10) && (funct_p0 == F_MULT);
    assign bubble_p0 = (state == S_BUSY) || ((state == S_IDLE) && mult_p0);
    assign done_p0   = (state == S_DONE);
    assign prod_p0   = acc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_IDLE;
            count      <= '0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            cap_wr_p0  <= '0;
            cap_wb_p0  <= '0;
            cap_mem_p0 <= '0;
        end else if (bus.i_flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mult_p0) begin
                        mcand      <= op_a_p0;
                        mplier     <= op_b_p0;
                        acc        <= '0;
                        count      <= '0;
                        cap_wr_p0  <= wr_p0;
                        cap_wb_p0  <= bus.i_WB_control;
                        cap_mem_p0 <= bus.i_MEM_control;
                        state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Only the low 32 product bits are kept, so the mult is sign-agnostic
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 5'd1;
                    if (count == 5'd31) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
`else
    assign bubble_p0  = 1'b0;
    assign done_p0    = 1'b0;
    assign prod_p0    = '0;
    assign cap_wr_p0  = '0;
    assign cap_wb_p0  = '0;
    assign cap_mem_p0 = '0;
`endif

    assign bus.o_stall = !bus.i_flush && bubble_p0;

    // Stage p1: EX/MEM pipeline register
    logic [DATA_W-1:0] br_tgt_p1, res_p1, wd_p1;
    logic              zero_p1;
    logic [REG_AW-1:0] wr_p1;
    logic [1:0]        wb_p1;
    logic [2:0]        mem_p1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst || bus.i_flush || bubble_p0) begin
            br_tgt_p1 <= '0;
            res_p1    <= '0;
            wd_p1     <= '0;
            zero_p1   <= 1'b0;
            wr_p1     <= '0;
            wb_p1     <= '0;
            mem_p1    <= '0;
        end else if (done_p0) begin
            br_tgt_p1 <= br_tgt_p0;
            res_p1    <= prod_p0;
            wd_p1     <= bus.i_read_data2;
            zero_p1   <= (prod_p0 == '0);
            wr_p1     <= cap_wr_p0;
            wb_p1     <= cap_wb_p0;
            mem_p1    <= cap_mem_p0;
        end else begin
            br_tgt_p1 <= br_tgt_p0;
            res_p1    <= alu_p0;
            wd_p1     <= bus.i_read_data2;
            zero_p1   <= (alu_p0 == '0);
            wr_p1     <= wr_p0;
            wb_p1     <= bus.i_WB_control;
            mem_p1    <= bus.i_MEM_control;
        end
    end

    assign bus.o_branch_target = br_tgt_p1;
    assign bus.o_alu_result    = res_p1;
    assign bus.o_write_data    = wd_p1;
    assign bus.o_zero          = zero_p1;
    assign bus.o_write_reg     = wr_p1;
    assign bus.o_WB_control    = wb_p1;
    assign bus.o_MEM_control   = mem_p1;
endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage against an instruction-level reference model,
// with directed literal cases; multiplier cases are active when EX_MULT_EN is set.
module tb_ex_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();
    ex_stage #(.DATA_W(32), .REG_AW(5)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    typedef struct packed {
        logic [31:0] npc, rs, rt, imm;
        logic [4:0]  tar, des;
        logic [1:0]  wb;
        logic [2:0]  mem;
        logic [3:0]  ex;
    } instr_t;

    typedef struct packed {
        logic [31:0] bt;
        logic        zero;
        logic [31:0] res;
        logic [31:0] wd;
        logic [4:0]  wr;
        logic [1:0]  wb;
        logic [2:0]  mem;
    } out_t;

    int   total = 0;
    int   bad = 0;
    int   stall_cnt = 0;
    bit   chk_en = 1'b0;
    out_t exp_q = '0;
    out_t nxt = '0;
    logic exp_stall = 1'b0;

    function automatic out_t dut_out();
        out_t o;
        o.bt = bus.o_branch_target; o.zero = bus.o_zero; o.res = bus.o_alu_result;
        o.wd = bus.o_write_data;    o.wr = bus.o_write_reg;
        o.wb = bus.o_WB_control;    o.mem = bus.o_MEM_control;
        return o;
    endfunction

    // What EX/MEM must hold after an instruction completes (plain arithmetic).
    function automatic out_t model(instr_t x);
        out_t o;
        logic [31:0] b, r;
        logic [5:0]  f;
        b = x.ex[3] ? x.imm : x.rt;
        f = x.imm[5:0];
        case (x.ex[2:1])
            2'd0: r = x.rs + b;
            2'd1: r = x.rs - b;
            2'd3: r = x.rs | b;
            default: begin
                if (f == 6'h20) r = x.rs + b;
                else if (f == 6'h22) r = x.rs - b;
                else if (f == 6'h24) r = x.rs & b;
                else if (f == 6'h25) r = x.rs | b;
                else if (f == 6'h2A) r = ($signed(x.rs) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef EX_MULT_EN
                else if (f == 6'h18) r = x.rs * b;
`endif
                else r = 32'd0;
            end
        endcase
        o.bt = x.npc + x.imm * 4;
        o.zero = (r == 32'd0);
        o.res = r;
        o.wd = x.rt;
        o.wr = x.ex[0] ? x.des : x.tar;
        o.wb = x.wb;
        o.mem = x.mem;
        return o;
    endfunction

    function automatic bit is_mult(instr_t x);
`ifdef EX_MULT_EN
        return (x.ex[2:1] == 2'b10) && (x.imm[5:0] == 6'h18);
`else
        return 1'b0;
`endif
    endfunction

    function automatic instr_t mk(logic [31:0] npc, logic [31:0] rs, logic [31:0] rt,
                                  logic [31:0] imm, logic [4:0] tar, logic [4:0] des,
                                  logic [1:0] wb, logic [2:0] mem, logic [3:0] ex);
        instr_t x;
        x.npc = npc; x.rs = rs; x.rt = rt; x.imm = imm; x.tar = tar; x.des = des;
        x.wb = wb; x.mem = mem; x.ex = ex;
        return x;
    endfunction

    always @(negedge clk) begin
        if (bus.o_stall) stall_cnt++;
        if (chk_en) begin
            total++;
            if (dut_out() !== exp_q) begin
                bad++;
                $display("FAIL exmem t=%0t got=%h want=%h", $time, dut_out(), exp_q);
            end
            total++;
            if (bus.o_stall !== exp_stall) begin
                bad++;
                $display("FAIL stall t=%0t got=%b want=%b", $time, bus.o_stall, exp_stall);
            end
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, want);
        end
    endtask

    task automatic drive(instr_t x, bit fl);
        bus.i_flush = fl;        bus.i_next_pc = x.npc;   bus.i_read_data1 = x.rs;
        bus.i_read_data2 = x.rt; bus.i_imm = x.imm;       bus.i_tar_reg = x.tar;
        bus.i_des_reg = x.des;   bus.i_WB_control = x.wb; bus.i_MEM_control = x.mem;
        bus.i_EX_control = x.ex;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        exp_q = nxt;
    endtask

    // Presents one instruction for as long as the stage needs it; flush_at
    // selects the cycle (relative to first presentation) to flush, -1 for none.
    task automatic exec(instr_t x, int flush_at);
        bit fl;
        if (is_mult(x)) begin
            for (int c = 0; c < 34; c++) begin
                fl = (c == flush_at);
                drive(x, fl);
                exp_stall = !fl && (c < 33);
                nxt = (fl || c < 33) ? out_t'(0) : model(x);
                tick();
                if (fl) return;
            end
        end else begin
            fl = (flush_at == 0);
            drive(x, fl);
            exp_stall = 1'b0;
            nxt = fl ? out_t'(0) : model(x);
            tick();
        end
    endtask

    task automatic async_reset(string nm);
        #3;
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        chk({nm, "_outs"}, {31'd0, |dut_out()}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q = '0;
        chk_en = 1'b1;
    endtask

    function automatic instr_t rnd_instr();
        instr_t x;
        logic [31:0] v;
        x.npc = $urandom; x.rs = $urandom; x.rt = $urandom; x.imm = $urandom;
        x.tar = 5'($urandom); x.des = 5'($urandom);
        x.wb = 2'($urandom); x.mem = 3'($urandom); x.ex = 4'($urandom);
        if ($urandom_range(0, 3) == 0) x.rs = x.rt;
        if ($urandom_range(0, 3) == 0) begin
            x.rs = 32'($urandom_range(0, 20));
            x.rt = 32'($urandom_range(0, 20)) - 32'd10;
        end
        if (x.ex[2:1] == 2'b10) begin
            v = $urandom;
            case ($urandom_range(0, 6))
                0: x.imm[5:0] = 6'h20;
                1: x.imm[5:0] = 6'h22;
                2: x.imm[5:0] = 6'h24;
                3: x.imm[5:0] = 6'h25;
                4: x.imm[5:0] = 6'h2A;
                5: x.imm[5:0] = 6'h18;
                default: x.imm[5:0] = v[5:0];
            endcase
        end
        return x;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t x;
        int fa;
        rst = 1'b1;
        drive('0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {31'd0, |dut_out()}, 32'd0);
        chk("reset_stall", {31'd0, bus.o_stall}, 32'd0);
        rst = 1'b0;
        exp_q = '0;
        chk_en = 1'b1;

        x = mk(32'h0, 32'd5, 32'd7, 32'h20, 5'd8, 5'd3, 2'b01, 3'b000, 4'b0101);
        exec(x, -1);
        chk("add_res", bus.o_alu_result, 32'd12);
        chk("add_wr", {27'd0, bus.o_write_reg}, 32'd3);
        chk("add_zero", {31'd0, bus.o_zero}, 32'd0);
        chk("add_wb", {30'd0, bus.o_WB_control}, 32'd1);

        x = mk(32'h100, 32'h55, 32'h55, 32'd3, 5'd1, 5'd2, 2'b00, 3'b001, 4'b0010);
        exec(x, -1);
        chk("beq_bt", bus.o_branch_target, 32'h10C);
        chk("beq_zero", {31'd0, bus.o_zero}, 32'd1);
        chk("beq_mem", {29'd0, bus.o_MEM_control}, 32'd1);

        x = mk(32'h4, 32'h40, 32'h0, 32'hFFFF_FFFC, 5'd9, 5'd6, 2'b11, 3'b010, 4'b1000);
        exec(x, -1);
        chk("lw_res", bus.o_alu_result, 32'h3C);
        chk("lw_wr", {27'd0, bus.o_write_reg}, 32'd9);
        chk("lw_mem", {29'd0, bus.o_MEM_control}, 32'd2);

        x = mk(32'h8, 32'hFFFF_FFFF, 32'd1, 32'h2A, 5'd1, 5'd2, 2'b01, 3'b000, 4'b0101);
        exec(x, -1);
        chk("slt_neg", bus.o_alu_result, 32'd1);
        x = mk(32'h8, 32'd1, 32'hFFFF_FFFF, 32'h2A, 5'd1, 5'd2, 2'b01, 3'b000, 4'b0101);
        exec(x, -1);
        chk("slt_pos", bus.o_alu_result, 32'd0);

        x = mk(32'h8, 32'hF0, 32'd0, 32'h0F, 5'd4, 5'd2, 2'b01, 3'b000, 4'b1110);
        exec(x, -1);
        chk("ori_res", bus.o_alu_result, 32'hFF);
        x = mk(32'h8, 32'd9, 32'd9, 32'h3F, 5'd4, 5'd2, 2'b01, 3'b000, 4'b0101);
        exec(x, -1);
        chk("unk_res", bus.o_alu_result, 32'd0);
        chk("unk_wb", {30'd0, bus.o_WB_control}, 32'd1);

        async_reset("rst_after_add");

`ifdef EX_MULT_EN
        x = mk(32'h20, 32'd6, 32'd7, 32'h18, 5'd1, 5'd4, 2'b01, 3'b000, 4'b0101);
        stall_cnt = 0;
        exec(x, -1);
        chk("mult_stall_cycles", 32'(stall_cnt), 32'd33);
        chk("mult_res", bus.o_alu_result, 32'd42);
        chk("mult_wr", {27'd0, bus.o_write_reg}, 32'd4);
        chk("mult_wb", {30'd0, bus.o_WB_control}, 32'd1);
        x.rs = 32'hFFFF_FFFF; x.rt = 32'd2;
        exec(x, -1);
        chk("mult_neg", bus.o_alu_result, 32'hFFFF_FFFE);

        exec(x, 11);
        chk("flush_wb", {30'd0, bus.o_WB_control}, 32'd0);
        exec(mk(32'h0, 32'd1, 32'd2, 32'h20, 5'd1, 5'd5, 2'b01, 3'b000, 4'b0101), -1);
        chk("after_flush", bus.o_alu_result, 32'd3);
        exec(x, 0);

        for (int c = 0; c < 7; c++) begin
            drive(x, 1'b0);
            exp_stall = 1'b1;
            nxt = '0;
            tick();
        end
        async_reset("rst_mid_mult");
        exec(x, -1);
        chk("mult_after_rst", bus.o_alu_result, 32'hFFFF_FFFE);
`endif

        for (int i = 0; i < 200; i++) begin
            x = rnd_instr();
            if (is_mult(x)) fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 33)) : -1;
            else fa = ($urandom_range(0, 9) == 0) ? 0 : -1;
            exec(x, fa);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
